adex_tdm_scheduler: RTL
=======================

Name: adex_tdm_scheduler

Overview:
Time-division scheduler that shares one external AdEx Euler-update datapath among N_NEURONS neuron state slots. On each tick it sweeps slots 0..N_NEURONS-1 in order. For each slot it sends the stored v/w (Q8.7, 15-bit signed) to the datapath over a req/ack handshake and writes back the result. Spike events are queued in a small FIFO for the output/event logic.

Parameters:
N_NEURONS, 4, number of neuron state slots (2..16); IDX_W = $clog2(N_NEURONS) is a derived localparam
FIFO_DEPTH, 4, spike event FIFO entries (power of 2, >=2)
V_INIT, -8320, reset/clear value of every v slot (-65.0 in Q8.7)
W_INIT, 0, reset/clear value of every w slot

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  sweep enable, sampled only in IDLE
tick  in  1  one-cycle pulse that starts a sweep
state_clr  in  1  loads V_INIT/W_INIT into all slots; honoured only in IDLE
upd_req  out  1  update request to datapath
upd_idx  out  IDX_W  slot under update
upd_v  out  15  current v of slot
upd_w  out  15  current w of slot
upd_ack  in  1  datapath result valid
upd_v_next  in  15  new v
upd_w_next  in  15  new w
upd_spike  in  1  slot spiked this step
spk_valid  out  1  event FIFO not empty
spk_idx  out  IDX_W  head event slot index
spk_ready  in  1  consumer pops head when spk_valid&spk_ready
busy  out  1  FSM not in IDLE
sweep_done  out  1  one-cycle pulse after last slot written back
overrun  out  1  sticky: tick arrived while busy
drop  out  1  sticky: spike lost because FIFO full
clr_flags  in  1  clears overrun and drop
rd_idx  in  IDX_W  debug read slot select
rd_v  out  15  combinational v[rd_idx]
rd_w  out  15  combinational w[rd_idx]

Behaviour:
- Reset (async): FSM=IDLE; all v=V_INIT, w=W_INIT; FIFO empty; upd_req=0, upd_idx=0, upd_v/upd_w=0; spk_valid=0, spk_idx=0; busy=0, sweep_done=0, overrun=0, drop=0. Reset mid-sweep abandons the sweep; there is no resume.
- FSM states: IDLE, LOAD, REQ, DONE.
- IDLE: tick&enable -> LOAD with cur_idx=0. tick&!enable is ignored and does not set overrun. state_clr (with or without tick) takes priority: all slots are reinitialised that cycle and the tick is ignored.
- LOAD: registers upd_idx=cur_idx, upd_v=v[cur_idx], upd_w=w[cur_idx]; next state REQ.
- REQ: upd_req=1 with idx/v/w held stable until a cycle where upd_ack=1. On that cycle, v/w[cur_idx] take upd_v_next/upd_w_next at the clock edge and upd_req drops next cycle. If cur_idx==N_NEURONS-1 -> DONE, else cur_idx+1 and -> LOAD.
- upd_ack while upd_req=0 is ignored.
- Minimum per-slot cost is 2 cycles (LOAD + 1-cycle REQ with immediate ack).
- DONE: sweep_done=1 for one cycle, then -> IDLE.
- enable deasserted mid-sweep does not abort; the sweep completes.
- tick while busy (LOAD/REQ/DONE): tick is ignored and overrun is set.
- state_clr while busy is ignored.
- Writeback is a raw copy: no saturation or arithmetic inside this block.
- FIFO push: on the ack cycle when upd_spike=1, pushes cur_idx.
  - Full with no pop that cycle: event discarded, drop set.
  - Full with simultaneous pop: push accepted, occupancy unchanged.
  - Empty: spk_valid=0 and a pop request is ignored.
- spk_idx is the registered head entry, valid whenever spk_valid=1. FIFO order is strict in slot/sweep order.
- Sticky flags: clr_flags clears overrun and drop. If a set event and clr_flags occur in the same cycle, set wins.
- Read port: rd_v/rd_w show written-back values from the cycle after the ack edge.

Optional Feature:
Macro ADEX_SCHED_MASK_EN.
- Defined: adds input neuron_mask [N_NEURONS-1:0], sampled in IDLE on the starting tick and held for the sweep.
  - Masked-off slots are skipped entirely: no LOAD, no request, state held, no event.
  - The sweep still ends with a sweep_done pulse.
  - An all-zero mask goes IDLE -> DONE -> IDLE with sweep_done only.
- Undefined: port absent; every slot is updated each sweep.

Test Plan:
1. Reset, then rd_idx=0..3 -> rd_v=-8320 (0x5F80), rd_w=0; all outputs 0.
2. enable=1, tick pulse, model acks 1 cycle after each req and returns v_next=v+128, w_next=w+1 -> upd_idx goes 0,1,2,3; sweep_done pulses once; slot k then reads v=-8192, w=1; busy is high for exactly 4x3+1 cycles.
3. Second tick while busy in step 2 -> overrun=1 and the sweep is unaffected; clr_flags -> overrun=0; clr_flags together with a new overrun -> overrun stays 1.
4. upd_spike=1 for slots 0–3 over two sweeps, FIFO_DEPTH=4, spk_ready=0 -> first 4 events queued (0,1,2,3), next 4 dropped, drop=1; pop with spk_ready -> heads 0,1,2,3 in order, then spk_valid=0.
5. Ack delayed 5 cycles with upd_ack pulses injected while upd_req=0 -> stray acks ignored; upd_v/upd_w stay stable through the wait; state_clr during the sweep is ignored, state_clr in IDLE restores V_INIT/W_INIT.
6. rst_n asserted mid-REQ of slot 2 -> upd_req=0 immediately; after release, all slots read V_INIT and FIFO empty. With ADEX_SCHED_MASK_EN defined and mask=4'b0101 -> only idx 0 and 2 are requested.

Source files
------------

// File: rtl/adex_tdm_scheduler_if.sv
// Bundle between the TDM scheduler, the shared AdEx update datapath and the
// spike-event consumer.
//
// Handshakes (both follow valid/ready rules):
//   update : upd_req is the valid, upd_ack the ready. While upd_req=1 the
//            payload (upd_idx/upd_v/upd_w) is held stable; the transfer happens
//            on the first clock edge where upd_req=1 and upd_ack=1, and the
//            datapath result (upd_v_next/upd_w_next/upd_spike) is taken on
//            that same edge. upd_ack with upd_req=0 has no effect.
//   events : spk_valid/spk_idx are the valid/payload, spk_ready the ready.
//            The head pops on an edge with spk_valid=1 and spk_ready=1; the
//            payload never changes while spk_valid=1 and spk_ready=0.
interface adex_tdm_scheduler_if #(
    parameter int IDX_W = 2
);
    logic             upd_req;
    logic [IDX_W-1:0] upd_idx;
    logic [14:0]      upd_v;
    logic [14:0]      upd_w;
    logic             upd_ack;
    logic [14:0]      upd_v_next;
    logic [14:0]      upd_w_next;
    logic             upd_spike;
    logic             spk_valid;
    logic [IDX_W-1:0] spk_idx;
    logic             spk_ready;

    modport master (
        output upd_req, upd_idx, upd_v, upd_w,
        input  upd_ack, upd_v_next, upd_w_next, upd_spike,
        output spk_valid, spk_idx,
        input  spk_ready
    );

    modport slave (
        input  upd_req, upd_idx, upd_v, upd_w,
        output upd_ack, upd_v_next, upd_w_next, upd_spike,
        input  spk_valid, spk_idx,
        output spk_ready
    );
endinterface

// File: rtl/adex_tdm_scheduler.sv
// adex_tdm_scheduler: shares one external AdEx Euler-update datapath among
// N_NEURONS v/w state slots (Q8.7, 15-bit). Each accepted tick sweeps the
// slots in ascending order, one LOAD + REQ pair per slot, writes the datapath
// result straight back and queues spike events in a small FIFO.
// Optional build macro ADEX_SCHED_MASK_EN adds a neuron_mask input; slots whose
// mask bit is 0 are skipped for the whole sweep.
// dbg_state exposes the FSM state (IDLE=0, LOAD=1, REQ=2, DONE=3).
module adex_tdm_scheduler #(
    parameter int N_NEURONS  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int V_INIT     = -8320,
    parameter int W_INIT     = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         tick,
    input  logic                         state_clr,
    input  logic                         clr_flags,
`ifdef ADEX_SCHED_MASK_EN
    input  logic [N_NEURONS-1:0]         neuron_mask,
`endif
    adex_tdm_scheduler_if.master         bus,
    input  logic [$clog2(N_NEURONS)-1:0] rd_idx,
    output logic [14:0]                  rd_v,
    output logic [14:0]                  rd_w,
    output logic                         busy,
    output logic                         sweep_done,
    output logic                         overrun,
    output logic                         drop,
    output logic [1:0]                   dbg_state
);
    localparam int IDX_W  = $clog2(N_NEURONS);
    localparam int FPTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = FPTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [14:0] V_RST = 15'(V_INIT);
    localparam logic [14:0] W_RST = 15'(W_INIT);

    typedef enum logic [1:0] {IDLE, LOAD, REQ, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] cur_idx;
    logic [14:0]      v_mem [N_NEURONS];
    logic [14:0]      w_mem [N_NEURONS];

    logic [IDX_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [FPTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [CNT_W-1:0] count, count_next;
    logic             push_req, pop, full, push, drop_evt;
    logic [IDX_W-1:0] head_next;

    logic [N_NEURONS-1:0] mask_start, mask_live;
    logic [IDX_W:0]       first_hit, after_hit;

    // Lowest enabled slot at or above 'from'; MSB flags that one was found.
    function automatic logic [IDX_W:0] next_slot(input logic [N_NEURONS-1:0] m, input int from);
        logic [IDX_W:0] r;
        r = '0;
        for (int i = N_NEURONS - 1; i >= 0; i--) begin
            if (i >= from && m[i]) r = {1'b1, IDX_W'(i)};
        end
        return r;
    endfunction

`ifdef ADEX_SCHED_MASK_EN
    logic [N_NEURONS-1:0] mask_q;

    // Mask is captured on the starting tick and held for the whole sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mask_q <= '0;
        else if (state == IDLE && !state_clr && tick && enable) mask_q <= neuron_mask;
    end

    assign mask_start = neuron_mask;
    assign mask_live  = mask_q;
`else
    assign mask_start = '1;
    assign mask_live  = '1;
`endif

    // Slot selection: first slot of a new sweep, and the slot after cur_idx.
    always_comb begin
        first_hit = next_slot(mask_start, 0);
        after_hit = next_slot(mask_live, int'(cur_idx) + 1);
    end

    // Sweep FSM, state memory writeback and registered datapath-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cur_idx     <= '0;
            bus.upd_req <= 1'b0;
            bus.upd_idx <= '0;
            bus.upd_v   <= '0;
            bus.upd_w   <= '0;
            busy        <= 1'b0;
            sweep_done  <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) begin
                v_mem[i] <= V_RST;
                w_mem[i] <= W_RST;
            end
        end else begin
            sweep_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (state_clr) begin
                        for (int i = 0; i < N_NEURONS; i++) begin
                            v_mem[i] <= V_RST;
                            w_mem[i] <= W_RST;
                        end
                    end else if (tick && enable) begin
                        busy <= 1'b1;
                        if (first_hit[IDX_W]) begin
                            cur_idx <= first_hit[IDX_W-1:0];
                            state   <= LOAD;
                        end else begin
                            sweep_done <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                LOAD: begin
                    bus.upd_idx <= cur_idx;
                    bus.upd_v   <= v_mem[cur_idx];
                    bus.upd_w   <= w_mem[cur_idx];
                    bus.upd_req <= 1'b1;
                    state       <= REQ;
                end
                REQ: begin
                    if (bus.upd_ack) begin
                        v_mem[cur_idx] <= bus.upd_v_next;
                        w_mem[cur_idx] <= bus.upd_w_next;
                        bus.upd_req    <= 1'b0;
                        if (after_hit[IDX_W]) begin
                            cur_idx <= after_hit[IDX_W-1:0];
                            state   <= LOAD;
                        end else begin
                            sweep_done <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Event FIFO control: a push into a full FIFO survives only if the head pops.
    always_comb begin
        push_req   = (state == REQ) && bus.upd_ack && bus.upd_spike;
        pop        = bus.spk_valid && bus.spk_ready;
        full       = (count == DEPTH_C);
        push       = push_req && (!full || pop);
        drop_evt   = push_req && full && !pop;
        rd_nxt     = rd_ptr + 1'b1;
        count_next = count;
        if (push && !pop) count_next = count + 1'b1;
        else if (pop && !push) count_next = count - 1'b1;
        head_next = bus.spk_idx;
        if (pop) begin
            if (count > 1) head_next = fifo_mem[rd_nxt];
            else if (push) head_next = cur_idx;
        end else if (count == '0 && push) begin
            head_next = cur_idx;
        end
    end

    // Event FIFO storage with a registered head entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.spk_valid <= 1'b0;
            bus.spk_idx   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= cur_idx;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_nxt;
            count         <= count_next;
            bus.spk_valid <= (count_next != '0);
            bus.spk_idx   <= head_next;
        end
    end

    // Sticky status flags; a new event in the clearing cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
            drop    <= 1'b0;
        end else begin
            if (tick && state != IDLE) overrun <= 1'b1;
            else if (clr_flags)        overrun <= 1'b0;
            if (drop_evt)              drop <= 1'b1;
            else if (clr_flags)        drop <= 1'b0;
        end
    end

    // Debug read port and state visibility.
    always_comb begin
        rd_v = '0;
        rd_w = '0;
        if (int'(rd_idx) < N_NEURONS) begin
            rd_v = v_mem[rd_idx];
            rd_w = w_mem[rd_idx];
        end
    end

    assign dbg_state = state;
endmodule
